// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and data memory (DM)
// requesters. Data accesses normally win, but a saturating starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive data grants taken while
// a fetch was waiting.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   if_req/if_addr        fetch request and address (held until if_ready)
//   if_rdata/if_ready     fetched word and one-cycle completion pulse
//   dm_read/dm_write      data load/store request (held until dm_ready)
//   dm_addr/dm_wdata      data address and store data
//   dm_rdata/dm_ready     load data and one-cycle completion pulse
//   mem_req/mem_we        shared memory request and write enable
//   mem_addr/mem_wdata    shared memory address and write data (registered)
//   mem_rdata/mem_ack     shared memory read data and completion
//   stall_if/stall_mem    pipeline freeze while a request is outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [AW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [AW-1:0] dm_wdata,
  output logic [AW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   wdata_r;
  logic            we_r;
  logic            req_r;
  logic [CW-1:0]   starve_cnt_r;

  logic            dm_req_s;
  logic            starved_s;
  logic            grant_dm_s;
  logic            grant_if_s;

  // Grant decision: data wins unless the waiting fetch has hit the starvation limit.
  always_comb begin
    dm_req_s   = dm_read | dm_write;
    starved_s  = (starve_cnt_r == LIMIT);
    grant_dm_s = 1'b0;
    grant_if_s = 1'b0;
    if (state_r == IDLE) begin
      if (dm_req_s && !(if_req && starved_s)) begin
        grant_dm_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_dm_s = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_dm_s = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Ownership FSM with latched transaction fields and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      req_r        <= 1'b0;
      starve_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_dm_s) begin
            state_r <= DM_BUSY;
            req_r   <= 1'b1;
            addr_r  <= dm_addr;
            wdata_r <= dm_wdata;
            // A simultaneous read+write is carried out as a write.
            we_r    <= dm_write;
            if (if_req && (starve_cnt_r != LIMIT)) begin
              starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end else if (grant_if_s) begin
            state_r      <= IF_BUSY;
            req_r        <= 1'b1;
            addr_r       <= if_addr;
            wdata_r      <= '0;
            we_r         <= 1'b0;
            starve_cnt_r <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          // Hold the port until the memory acknowledges, even if the
          // requester has already dropped its request.
          if (mem_ack) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = req_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Completion pulses are qualified by ownership so an ack in IDLE is ignored.
  assign if_ready  = mem_ack & (state_r == IF_BUSY);
  assign dm_ready  = mem_ack & (state_r == DM_BUSY);

  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (dm_read | dm_write) & ~dm_ready;

endmodule
